// File: rtl/writeback_scoreboard_pkg.sv
// Shared widths, depths and the completion-entry type for the writeback scoreboard.
package writeback_scoreboard_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned WB_FIFO_DEPTH = 4;
  localparam int unsigned WB_CNT_W      = $clog2(WB_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_scoreboard_wb_fifo.sv
// In-order completion FIFO with two push ports (port a lands ahead of port b) and one pop port.
module wb_fifo
  import writeback_scoreboard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_a_valid_i,
  input  wb_entry_t           push_a_entry_i,
  input  logic                push_b_valid_i,
  input  wb_entry_t           push_b_entry_i,
  input  logic                pop_i,
  output wb_entry_t           head_o,
  output logic [WB_CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(WB_FIFO_DEPTH);

  wb_entry_t             mem_q [WB_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       slot_b;
  logic [WB_CNT_W-1:0]   count_q, count_d;
  logic [1:0]            num_push;
  logic                  pop_en;

  always_comb begin
    pop_en   = pop_i && (count_q != '0);
    num_push = {1'b0, push_a_valid_i} + {1'b0, push_b_valid_i};
    // Port b takes the slot after port a when both push together.
    slot_b   = push_a_valid_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PtrW'(num_push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_en);
    count_d  = count_q + WB_CNT_W'(num_push) - WB_CNT_W'(pop_en);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (push_a_valid_i) mem_q[wr_ptr_q] <= push_a_entry_i;
      if (push_b_valid_i) mem_q[slot_b]   <= push_b_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_scoreboard.sv
// Register busy scoreboard with RAW/WAW issue stall, and a registered writeback port fed by
// an in-order FIFO of mem/ALU completions.
module writeback_scoreboard
  import writeback_scoreboard_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] issueRs1,
  input  logic [REG_ADDR_W-1:0] issueRs2,
  output logic                  issueStall,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [XLEN-1:0]       aluData,
  output logic                  aluReady,
  input  logic                  memValid,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic [XLEN-1:0]       memData,
  output logic                  memReady,
  output logic                  writeRegister,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       dataToWrite,
  output logic [XLEN-1:0]       busyMask
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_W;
  // Ready thresholds leave room for both sources landing in the same cycle.
  localparam logic [WB_CNT_W-1:0] MemReadyMax = WB_CNT_W'(WB_FIFO_DEPTH - 1);
  localparam logic [WB_CNT_W-1:0] AluReadyMax = WB_CNT_W'(WB_FIFO_DEPTH - 2);

  logic [NumRegs-1:0]    busy_q, busy_d;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;

  wb_entry_t             mem_entry, alu_entry, head;
  logic [WB_CNT_W-1:0]   count;
  logic                  mem_push, alu_push, pop, issue_fire;

  always_comb begin
    issueStall = reset ||
                 (issueValid && (busy_q[issueRs1] || busy_q[issueRs2] || busy_q[issueRd]));
    memReady   = !reset && (count <= MemReadyMax);
    aluReady   = !reset && (count <= AluReadyMax);
    issue_fire = issueValid && !issueStall;
    mem_push   = memValid && memReady && (memRd != '0);
    alu_push   = aluValid && aluReady && (aluRd != '0);
    pop        = (count != '0);
    mem_entry  = '{rd: memRd, data: memData};
    alu_entry  = '{rd: aluRd, data: aluData};
  end

  always_comb begin
    busy_d = busy_q;
    if (pop)        busy_d[head.rd] = 1'b0;
    if (issue_fire) busy_d[issueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  wb_fifo u_wb_fifo (
    .clk_i          (clock),
    .rst_i          (reset),
    .push_a_valid_i (mem_push),
    .push_a_entry_i (mem_entry),
    .push_b_valid_i (alu_push),
    .push_b_entry_i (alu_entry),
    .pop_i          (pop),
    .head_o         (head),
    .count_o        (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      wr_en_q <= pop;
      if (pop) begin
        rd_q   <= head.rd;
        data_q <= head.data;
      end
    end
  end

  assign writeRegister = wr_en_q;
  assign rd            = rd_q;
  assign dataToWrite   = data_q;
  assign busyMask      = busy_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_writeback_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issueValid;
  logic [4:0]  issueRd, issueRs1, issueRs2;
  logic        issueStall;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        memReady;
  logic        writeRegister;
  logic [4:0]  rd;
  logic [31:0] dataToWrite;
  logic [31:0] busyMask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  writeback_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issueValid    (issueValid),
    .issueRd       (issueRd),
    .issueRs1      (issueRs1),
    .issueRs2      (issueRs2),
    .issueStall    (issueStall),
    .aluValid      (aluValid),
    .aluRd         (aluRd),
    .aluData       (aluData),
    .aluReady      (aluReady),
    .memValid      (memValid),
    .memRd         (memRd),
    .memData       (memData),
    .memReady      (memReady),
    .writeRegister (writeRegister),
    .rd            (rd),
    .dataToWrite   (dataToWrite),
    .busyMask      (busyMask)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issueValid = 0; issueRd = 0; issueRs1 = 0; issueRs2 = 0;
    aluValid = 0; aluRd = 0; aluData = 0;
    memValid = 0; memRd = 0; memData = 0;
  endtask

  task automatic test_reset();
    reset = 1; issueValid = 1; issueRd = 5'd9; issueRs1 = 5'd1; issueRs2 = 5'd2;
    memValid = 1; memRd = 5'd4; memData = $urandom; aluValid = 1; aluRd = 5'd6; aluData = $urandom;
    #1;
    total++; if (aluReady !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%0h exp=0", aluReady); end
    total++; if (memReady !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%0h exp=0", memReady); end
    total++; if (issueStall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%0h exp=1", issueStall); end
    tick();
    total++; if (writeRegister !== 1'b0) begin bad++; $display("FAIL rst_wr got=%0h exp=0", writeRegister); end
    total++; if (rd !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0h exp=0", rd); end
    total++; if (dataToWrite !== 32'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", dataToWrite); end
    total++; if (busyMask !== 32'd0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busyMask); end
    reset = 0; idle();
    #1;
    total++; if (aluReady !== 1'b1) begin bad++; $display("FAIL rel_alu_ready got=%0h exp=1", aluReady); end
    total++; if (memReady !== 1'b1) begin bad++; $display("FAIL rel_mem_ready got=%0h exp=1", memReady); end
    total++; if (issueStall !== 1'b0) begin bad++; $display("FAIL rel_stall got=%0h exp=0", issueStall); end
    tick();
  endtask

  task automatic test_raw_hazard();
    idle();
    issueValid = 1; issueRd = 5'd5; issueRs1 = 5'd1; issueRs2 = 5'd2;
    #1;
    total++; if (issueStall !== 1'b0) begin bad++; $display("FAIL raw_free_stall got=%0h exp=0", issueStall); end
    tick();
    total++; if (busyMask !== 32'h20) begin bad++; $display("FAIL raw_busy_set got=%0h exp=20", busyMask); end
    issueRd = 5'd6; issueRs1 = 5'd5; issueRs2 = 5'd0;
    #1;
    total++; if (issueStall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%0h exp=1", issueStall); end
    idle(); memValid = 1; memRd = 5'd5; memData = 32'hDEADBEEF;
    #1;
    total++; if (memReady !== 1'b1) begin bad++; $display("FAIL raw_mem_ready got=%0h exp=1", memReady); end
    tick();
    idle();
    total++; if (writeRegister !== 1'b0) begin bad++; $display("FAIL raw_early_wr got=%0h exp=0", writeRegister); end
    tick();
    total++; if (writeRegister !== 1'b1) begin bad++; $display("FAIL raw_wr got=%0h exp=1", writeRegister); end
    total++; if (rd !== 5'd5) begin bad++; $display("FAIL raw_rd got=%0h exp=5", rd); end
    total++; if (dataToWrite !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_data got=%0h exp=deadbeef", dataToWrite); end
    total++; if (busyMask !== 32'h0) begin bad++; $display("FAIL raw_busy_clr got=%0h exp=0", busyMask); end
    issueValid = 1; issueRd = 5'd0; issueRs1 = 5'd5;
    #1;
    total++; if (issueStall !== 1'b0) begin bad++; $display("FAIL raw_stall_drop got=%0h exp=0", issueStall); end
    tick();
    idle();
    total++; if (writeRegister !== 1'b0) begin bad++; $display("FAIL raw_wr_idle got=%0h exp=0", writeRegister); end
  endtask

  task automatic test_dual_completion();
    idle();
    memValid = 1; memRd = 5'd3; memData = 32'h11;
    aluValid = 1; aluRd = 5'd4; aluData = 32'h22;
    tick();
    idle();
    tick();
    total++; if (writeRegister !== 1'b1 || rd !== 5'd3 || dataToWrite !== 32'h11) begin
      bad++; $display("FAIL dual_first got=%0h/%0h/%0h exp=1/3/11", writeRegister, rd, dataToWrite); end
    tick();
    total++; if (writeRegister !== 1'b1 || rd !== 5'd4 || dataToWrite !== 32'h22) begin
      bad++; $display("FAIL dual_second got=%0h/%0h/%0h exp=1/4/22", writeRegister, rd, dataToWrite); end
    tick();
    total++; if (writeRegister !== 1'b0 || rd !== 5'd4 || dataToWrite !== 32'h22) begin
      bad++; $display("FAIL dual_hold got=%0h/%0h/%0h exp=0/4/22", writeRegister, rd, dataToWrite); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  got_rd[$];
    logic [31:0] got_data[$];
    logic        take;
    idle();
    memValid = 1; memRd = 5'd1; memData = 32'h101; aluValid = 1; aluRd = 5'd2; aluData = 32'h102;
    tick();
    memRd = 5'd3; memData = 32'h103; aluRd = 5'd4; aluData = 32'h104;
    #1;
    total++; if (aluReady !== 1'b1) begin bad++; $display("FAIL bp_alu_ready2 got=%0h exp=1", aluReady); end
    tick();
    total++; if (rd !== 5'd1 || writeRegister !== 1'b1) begin bad++; $display("FAIL bp_pop1 got=%0h exp=1", rd); end
    memRd = 5'd5; memData = 32'h105; aluRd = 5'd6; aluData = 32'h106;
    #1;
    total++; if (aluReady !== 1'b0) begin bad++; $display("FAIL bp_alu_ready3 got=%0h exp=0", aluReady); end
    total++; if (memReady !== 1'b1) begin bad++; $display("FAIL bp_mem_ready3 got=%0h exp=1", memReady); end
    tick();
    total++; if (rd !== 5'd2 || writeRegister !== 1'b1) begin bad++; $display("FAIL bp_pop2 got=%0h exp=2", rd); end
    memValid = 0;
    for (int i = 0; i < 8; i++) begin
      take = aluValid && aluReady;
      tick();
      if (take) aluValid = 0;
      if (writeRegister) begin got_rd.push_back(rd); got_data.push_back(dataToWrite); end
    end
    idle();
    total++; if (got_rd.size() != 4) begin bad++; $display("FAIL bp_write_count got=%0d exp=4", got_rd.size()); end
    for (int i = 0; i < got_rd.size() && i < 4; i++) begin
      total++;
      if (got_rd[i] !== 5'(i + 3) || got_data[i] !== 32'(32'h100 + i + 3)) begin
        bad++; $display("FAIL bp_order[%0d] got=%0h/%0h exp=%0h/%0h", i, got_rd[i], got_data[i],
                        i + 3, 32'h100 + i + 3);
      end
    end
  endtask

  task automatic test_zero_rd();
    idle();
    memValid = 1; memRd = 5'd0; memData = 32'hFFFFFFFF;
    aluValid = 1; aluRd = 5'd0; aluData = 32'hFFFFFFFF;
    tick();
    idle();
    total++; if (writeRegister !== 1'b0) begin bad++; $display("FAIL zero_wr1 got=%0h exp=0", writeRegister); end
    memValid = 1; memRd = 5'd9; memData = 32'h99;
    tick();
    idle();
    total++; if (writeRegister !== 1'b0) begin bad++; $display("FAIL zero_wr2 got=%0h exp=0", writeRegister); end
    tick();
    total++; if (writeRegister !== 1'b1 || rd !== 5'd9 || dataToWrite !== 32'h99) begin
      bad++; $display("FAIL zero_next got=%0h/%0h/%0h exp=1/9/99", writeRegister, rd, dataToWrite); end
    issueValid = 1; issueRd = 5'd7;
    tick();
    total++; if (busyMask !== 32'h80) begin bad++; $display("FAIL zero_busy7 got=%0h exp=80", busyMask); end
    issueRd = 5'd0;
    #1;
    total++; if (issueStall !== 1'b0) begin bad++; $display("FAIL zero_issue_stall got=%0h exp=0", issueStall); end
    tick();
    total++; if (busyMask !== 32'h80) begin bad++; $display("FAIL zero_issue_busy got=%0h exp=80", busyMask); end
    idle(); memValid = 1; memRd = 5'd7; memData = 32'h77;
    tick();
    idle();
    tick();
    total++; if (busyMask !== 32'h0) begin bad++; $display("FAIL zero_busy_clr got=%0h exp=0", busyMask); end
  endtask

  task automatic test_reset_flush();
    idle();
    issueValid = 1; issueRd = 5'd1;
    memValid = 1; memRd = 5'd5; memData = 32'h55; aluValid = 1; aluRd = 5'd6; aluData = 32'h66;
    tick();
    issueRd = 5'd2; memRd = 5'd7; memData = 32'h77; aluRd = 5'd8; aluData = 32'h88;
    #1;
    total++; if (aluReady !== 1'b1) begin bad++; $display("FAIL flush_alu_ready got=%0h exp=1", aluReady); end
    tick();
    issueRd = 5'd3; memRd = 5'd9; memData = 32'h99; aluValid = 0;
    tick();
    idle();
    total++; if (busyMask !== 32'h0E) begin bad++; $display("FAIL flush_busy got=%0h exp=e", busyMask); end
    reset = 1;
    #1;
    total++; if (memReady !== 1'b0 || aluReady !== 1'b0 || issueStall !== 1'b1) begin
      bad++; $display("FAIL flush_in_reset got=%0h/%0h/%0h exp=0/0/1", memReady, aluReady, issueStall); end
    tick();
    total++; if (writeRegister !== 1'b0 || busyMask !== 32'h0 || rd !== 5'd0 || dataToWrite !== 32'h0) begin
      bad++; $display("FAIL flush_state got=%0h/%0h/%0h/%0h exp=0/0/0/0", writeRegister, busyMask, rd, dataToWrite); end
    reset = 0;
    #1;
    total++; if (aluReady !== 1'b1) begin bad++; $display("FAIL flush_alu_rel got=%0h exp=1", aluReady); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (writeRegister !== 1'b0) begin bad++; $display("FAIL flush_stale_wr%0d got=%0h exp=0", i, writeRegister); end
    end
  endtask

  task automatic test_random(input int n);
    ent_t        mq[$];
    ent_t        h;
    int          pend[$];
    bit          mbusy[32];
    logic        ew, es, emr, ear;
    logic [4:0]  er;
    logic [31:0] ed, emask;
    int          mi, ai, d0, d1;
    idle();
    reset = 1;
    tick();
    reset = 0;
    ew = 0; er = 0; ed = 0;
    for (int i = 0; i < 32; i++) mbusy[i] = 0;
    for (int c = 0; c < n; c++) begin
      issueValid = 1'($urandom_range(0, 1));
      issueRd  = 5'($urandom_range(0, 7));
      issueRs1 = 5'($urandom_range(0, 7));
      issueRs2 = 5'($urandom_range(0, 7));
      memValid = 0; aluValid = 0; mi = -1; ai = -1;
      memData = $urandom; aluData = $urandom;
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        mi = $urandom_range(0, pend.size() - 1); memValid = 1; memRd = 5'(pend[mi]);
      end else if ($urandom_range(0, 7) == 0) begin
        memValid = 1; memRd = 5'd0;
      end
      if (pend.size() > ((mi >= 0) ? 1 : 0) && $urandom_range(0, 1) == 1) begin
        ai = $urandom_range(0, pend.size() - 1);
        if (ai == mi) ai = (ai + 1) % pend.size();
        aluValid = 1; aluRd = 5'(pend[ai]);
      end else if ($urandom_range(0, 7) == 0) begin
        aluValid = 1; aluRd = 5'd0;
      end
      #1;
      es  = issueValid && (mbusy[issueRs1] || mbusy[issueRs2] || mbusy[issueRd]);
      emr = (mq.size() <= 3);
      ear = (mq.size() <= 2);
      total++; if (issueStall !== es) begin bad++; $display("FAIL rnd_stall c=%0d got=%0h exp=%0h", c, issueStall, es); end
      total++; if (memReady !== emr) begin bad++; $display("FAIL rnd_mem_ready c=%0d got=%0h exp=%0h", c, memReady, emr); end
      total++; if (aluReady !== ear) begin bad++; $display("FAIL rnd_alu_ready c=%0d got=%0h exp=%0h", c, aluReady, ear); end
      if (mq.size() > 0) begin
        h = mq.pop_front(); ew = 1; er = h.rd; ed = h.data; mbusy[h.rd] = 0;
      end else begin
        ew = 0;
      end
      if (issueValid && !es && issueRd != 0) begin mbusy[issueRd] = 1; pend.push_back(int'(issueRd)); end
      if (memValid && emr && memRd != 0) mq.push_back('{memRd, memData});
      if (aluValid && ear && aluRd != 0) mq.push_back('{aluRd, aluData});
      d0 = (memValid && emr) ? mi : -1;
      d1 = (aluValid && ear) ? ai : -1;
      if (d0 < d1) begin mi = d0; d0 = d1; d1 = mi; end
      if (d0 >= 0) pend.delete(d0);
      if (d1 >= 0) pend.delete(d1);
      tick();
      emask = '0;
      for (int i = 1; i < 32; i++) emask[i] = mbusy[i];
      total++; if (writeRegister !== ew) begin bad++; $display("FAIL rnd_wr c=%0d got=%0h exp=%0h", c, writeRegister, ew); end
      total++; if (rd !== er || dataToWrite !== ed) begin
        bad++; $display("FAIL rnd_out c=%0d got=%0h/%0h exp=%0h/%0h", c, rd, dataToWrite, er, ed); end
      total++; if (busyMask !== emask) begin bad++; $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", c, busyMask, emask); end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    tick();
    test_reset();
    test_raw_hazard();
    test_dual_completion();
    test_backpressure();
    test_zero_rd();
    test_reset_flush();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
